// File: rtl/adc_ltc2308_sequencer.sv
// adc_ltc2308_sequencer
//
// Scans a masked set of LTC2308 single-ended channels in ascending order.
// It drives the ADC's CONVST, SCLK and SDI pins and shifts in each 12-bit
// conversion code. The latest code for every channel is kept in a small
// register file with a per-channel "updated" flag.
//
// The LTC2308 returns the result of the config word sent in the previous
// transaction. Because of this, a frame over N channels runs N+1 transactions.
// Transaction 0's data is thrown away, and the last transaction repeats the
// final channel's config.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   enable              0 stops scanning at the next transaction boundary
//   start               one-cycle pulse, begins a frame when idle
//   auto_run            restart a frame right after each frame ends
//   ch_mask[7:0]        channels to scan, latched at frame start
//   busy                high from frame start to frame end
//   adc_convst/sclk/din ADC control pins, all registered
//   adc_dout            ADC serial data
//   result_valid/ch/data one-cycle result stream
//   rd_addr, rd_data    combinational register-file read {flag,3'b0,code}
//   rd_ack              clears the update flag of channel rd_addr

module adc_ltc2308_sequencer #(
   parameter int CONV_CYCLES = 170,
   parameter int SCLK_HALF   = 4,
   parameter int ACQ_CYCLES  = 40
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        start,
   input  logic        auto_run,
   input  logic [7:0]  ch_mask,
   output logic        busy,
   output logic        adc_convst,
   output logic        adc_sclk,
   output logic        adc_din,
   input  logic        adc_dout,
   output logic        result_valid,
   output logic [2:0]  result_ch,
   output logic [11:0] result_data,
   input  logic [2:0]  rd_addr,
   output logic [15:0] rd_data,
   input  logic        rd_ack
);

   typedef enum logic [1:0] {IDLE, CONV, SHIFT, ACQ} state_t;

   localparam logic [15:0] CONV_LAST = 16'(CONV_CYCLES - 1);
   localparam logic [15:0] HALF_LAST = 16'(SCLK_HALF - 1);
   localparam logic [15:0] ACQ_LAST  = 16'(ACQ_CYCLES - 1);

   state_t      state;
   logic [15:0] cnt;
   logic [3:0]  bit_idx;
   logic [7:0]  pending_mask;
   logic [2:0]  cfg_ch;
   logic [2:0]  prev_ch;
   logic        first_xact;
   logic        last_xact;
   logic        wr_pend;
   logic [11:0] shift_reg;
   logic [11:0] code_mem [8];
   logic [7:0]  upd_flag;

   // Lowest set bit of a channel mask (ascending scan order)
   function automatic logic [2:0] lowest_ch(input logic [7:0] m);
      logic [2:0] c;
      c = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i]) c = 3'(i);
      end
      return c;
   endfunction

   // SDI bit for shift position idx: 6-bit config word
   // {S/D=1, O/S=ch[0], S1=ch[2], S0=ch[1], UNI=1, SLP=0}, then zeros
   function automatic logic din_bit(input logic [2:0] ch, input logic [3:0] idx);
      logic [11:0] bits;
      bits = {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0, 6'b000000};
      return bits[4'd11 - idx];
   endfunction

   // Transaction sequencer: CONV -> SHIFT -> ACQ per transaction, all pins
   // registered. pending_mask holds channels whose config has not been sent
   // yet; when it runs dry, the last config is repeated once to flush the
   // pipelined final result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         cnt          <= '0;
         bit_idx      <= '0;
         pending_mask <= '0;
         cfg_ch       <= '0;
         prev_ch      <= '0;
         first_xact   <= 1'b0;
         last_xact    <= 1'b0;
         wr_pend      <= 1'b0;
         shift_reg    <= '0;
         busy         <= 1'b0;
         adc_convst   <= 1'b0;
         adc_sclk     <= 1'b0;
         adc_din      <= 1'b0;
         result_valid <= 1'b0;
         result_ch    <= '0;
         result_data  <= '0;
      end else begin
         wr_pend      <= 1'b0;
         result_valid <= wr_pend;
         if (wr_pend) begin
            result_ch   <= prev_ch;
            result_data <= shift_reg;
         end

         case (state)
            IDLE: begin
               adc_convst <= 1'b0;
               adc_sclk   <= 1'b0;
               adc_din    <= 1'b0;
               busy       <= 1'b0;
               if (enable && (start || auto_run) && (ch_mask != 8'd0)) begin
                  cfg_ch       <= lowest_ch(ch_mask);
                  pending_mask <= ch_mask & ~(8'd1 << lowest_ch(ch_mask));
                  first_xact   <= 1'b1;
                  last_xact    <= 1'b0;
                  busy         <= 1'b1;
                  adc_convst   <= 1'b1;
                  cnt          <= '0;
                  state        <= CONV;
               end
            end

            CONV: begin
               if (cnt == CONV_LAST) begin
                  adc_convst <= 1'b0;
                  adc_din    <= din_bit(cfg_ch, 4'd0);
                  bit_idx    <= '0;
                  cnt        <= '0;
                  state      <= SHIFT;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            // SDI only changes as SCLK falls; SDO is captured as SCLK rises
            SHIFT: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  if (!adc_sclk) begin
                     adc_sclk  <= 1'b1;
                     shift_reg <= {shift_reg[10:0], adc_dout};
                     if (bit_idx == 4'd11) wr_pend <= !first_xact;
                  end else begin
                     adc_sclk <= 1'b0;
                     if (bit_idx == 4'd11) begin
                        adc_din <= 1'b0;
                        state   <= ACQ;
                     end else begin
                        bit_idx <= bit_idx + 4'd1;
                        adc_din <= din_bit(cfg_ch, bit_idx + 4'd1);
                     end
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            ACQ: begin
               if (cnt == ACQ_LAST) begin
                  cnt <= '0;
                  if (last_xact || !enable) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     prev_ch    <= cfg_ch;
                     first_xact <= 1'b0;
                     adc_convst <= 1'b1;
                     state      <= CONV;
                     if (pending_mask != 8'd0) begin
                        cfg_ch       <= lowest_ch(pending_mask);
                        pending_mask <= pending_mask & ~(8'd1 << lowest_ch(pending_mask));
                     end else begin
                        last_xact <= 1'b1;
                     end
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   // Register file: a result write sets the channel's flag after any
   // same-cycle rd_ack clear, so a fresh code is never lost
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) code_mem[i] <= '0;
         upd_flag <= '0;
      end else begin
         if (rd_ack) upd_flag[rd_addr] <= 1'b0;
         if (result_valid) begin
            code_mem[result_ch] <= result_data;
            upd_flag[result_ch] <= 1'b1;
         end
      end
   end

   assign rd_data = {upd_flag[rd_addr], 3'b000, code_mem[rd_addr]};

endmodule

// File: tb/tb_adc_ltc2308_sequencer.sv
// tb_adc_ltc2308_sequencer
//
// Bench for adc_ltc2308_sequencer. An LTC2308 behavioural model decodes the
// config word on SDI and returns 12'h100 + channel, or an override code, for
// the channel configured in the previous transaction. Expected results are
// queued when a frame is started and popped whenever result_valid pulses.

module tb_adc_ltc2308_sequencer;

   localparam int CONV  = 170;
   localparam int HALF  = 4;
   localparam int ACQ   = 40;
   localparam int TRANS = CONV + 24 * HALF + ACQ;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic        start = 1'b0;
   logic        auto_run = 1'b0;
   logic [7:0]  ch_mask = 8'd0;
   logic        busy;
   logic        adc_convst;
   logic        adc_sclk;
   logic        adc_din;
   logic        adc_dout;
   logic        result_valid;
   logic [2:0]  result_ch;
   logic [11:0] result_data;
   logic [2:0]  rd_addr = 3'd0;
   logic [15:0] rd_data;
   logic        rd_ack = 1'b0;

   always #5 clk = ~clk;

   adc_ltc2308_sequencer #(
      .CONV_CYCLES(CONV),
      .SCLK_HALF(HALF),
      .ACQ_CYCLES(ACQ)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .enable(enable),
      .start(start),
      .auto_run(auto_run),
      .ch_mask(ch_mask),
      .busy(busy),
      .adc_convst(adc_convst),
      .adc_sclk(adc_sclk),
      .adc_din(adc_din),
      .adc_dout(adc_dout),
      .result_valid(result_valid),
      .result_ch(result_ch),
      .result_data(result_data),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .rd_ack(rd_ack)
   );

   int assert_count = 0;
   int fail_count = 0;

   typedef struct {
      logic [2:0]  ch;
      logic [11:0] data;
   } exp_t;
   exp_t exp_q[$];

   // ADC model state and monitor counters
   logic [11:0] adc_sr = 12'd0;
   logic [5:0]  cfg_sr = 6'd0;
   logic [5:0]  last_cfg_bits = 6'd0;
   logic [2:0]  last_cfg_ch = 3'd0;
   logic [2:0]  cfg_log[$];
   logic        override_en = 1'b0;
   logic [11:0] override_code = 12'd0;
   int sclk_bits = 0;
   int cyc = 0;
   int last_sclk_rise = 0;
   int last_sclk_period = 0;
   int convst_hi = 0;
   int last_convst_len = 0;
   int convst_rises = 0;
   int frame_count = 0;
   int busy_run = 0;
   int last_busy_len = 0;
   int low_run = 0;
   int last_low_len = 0;
   logic prev_convst = 1'b0;
   logic prev_sclk = 1'b0;
   logic prev_busy = 1'b0;

   assign adc_dout = adc_sr[11];

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assert_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // ADC model, pin timing monitors and result scoreboard, all sampled on
   // the falling clock edge, away from the DUT's active edge
   always @(negedge clk) begin
      cyc++;
      if (adc_convst && !prev_convst) begin
         convst_rises++;
         convst_hi = 0;
      end
      if (adc_convst) convst_hi++;
      if (!adc_convst && prev_convst) begin
         last_convst_len = convst_hi;
         adc_sr = override_en ? override_code : 12'h100 + {9'd0, last_cfg_ch};
         sclk_bits = 0;
      end
      if (adc_sclk && !prev_sclk) begin
         sclk_bits++;
         last_sclk_period = cyc - last_sclk_rise;
         last_sclk_rise = cyc;
         if (sclk_bits <= 6) cfg_sr = {cfg_sr[4:0], adc_din};
         if (sclk_bits == 6) begin
            last_cfg_bits = cfg_sr;
            last_cfg_ch = {cfg_sr[3], cfg_sr[2], cfg_sr[4]};
            cfg_log.push_back(last_cfg_ch);
         end
      end
      if (!adc_sclk && prev_sclk) adc_sr = {adc_sr[10:0], 1'b0};
      if (busy) begin
         if (!prev_busy) begin
            frame_count++;
            busy_run = 1;
            last_low_len = low_run;
         end else begin
            busy_run++;
         end
      end else begin
         if (prev_busy) begin
            last_busy_len = busy_run;
            low_run = 1;
         end else begin
            low_run++;
         end
      end
      if (result_valid) begin
         if (exp_q.size() == 0) begin
            checkOutput("sb_unexpected", 32'(exp_q.size()), 32'd1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("res_ch", 32'(result_ch), 32'(e.ch));
            checkOutput("res_data", 32'(result_data), 32'(e.data));
         end
      end
      prev_convst = adc_convst;
      prev_sclk = adc_sclk;
      prev_busy = busy;
   end

   // Queue the expected results for mask, then present it to the DUT
   task automatic applyStimulus(input logic [7:0] mask, input bit do_start, input bit push_exp);
      if (push_exp) begin
         for (int c = 0; c < 8; c++) begin
            if (mask[c]) begin
               exp_t e;
               e.ch = 3'(c);
               e.data = override_en ? override_code : 12'h100 + 12'(c);
               exp_q.push_back(e);
            end
         end
      end
      ch_mask = mask;
      start = do_start;
      tick();
      start = 1'b0;
      checkOutput("busy_rise", 32'(busy), 32'd1);
   endtask

   task automatic waitFrameEnd(input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      checkOutput("frame_end_timeout", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [2:0] exp_cfg [4];
      int fc;
      int cr;
      int n;

      // Reset state
      repeat (3) tick();
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_convst", 32'(adc_convst), 32'd0);
      checkOutput("rst_sclk", 32'(adc_sclk), 32'd0);
      checkOutput("rst_din", 32'(adc_din), 32'd0);
      checkOutput("rst_valid", 32'(result_valid), 32'd0);
      checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
      reset_n = 1'b1;
      enable = 1'b1;
      repeat (3) tick();

      // Multi-channel frame, mask 1010_0001
      $display("[TB] frame ch_mask=a1");
      cfg_log.delete();
      cr = convst_rises;
      applyStimulus(8'hA1, 1'b1, 1'b1);
      waitFrameEnd(5 * TRANS);
      tick();
      checkOutput("a1_busy_len", 32'(last_busy_len), 32'(4 * TRANS));
      checkOutput("a1_convst_count", 32'(convst_rises - cr), 32'd4);
      checkOutput("a1_cfg_count", 32'(cfg_log.size()), 32'd4);
      exp_cfg = '{3'd0, 3'd5, 3'd7, 3'd7};
      for (int i = 0; i < 4; i++) begin
         if (i < cfg_log.size()) checkOutput("a1_cfg_ch", 32'(cfg_log[i]), 32'(exp_cfg[i]));
      end
      checkOutput("a1_sb_empty", 32'(exp_q.size()), 32'd0);

      // Config encoding and pin timing, channel 6
      $display("[TB] frame ch_mask=40");
      cfg_log.delete();
      applyStimulus(8'h40, 1'b1, 1'b1);
      waitFrameEnd(3 * TRANS);
      tick();
      checkOutput("ch6_cfg_bits", 32'(last_cfg_bits), 32'b101110);
      checkOutput("ch6_cfg_count", 32'(cfg_log.size()), 32'd2);
      checkOutput("sclk_period", 32'(last_sclk_period), 32'(2 * HALF));
      checkOutput("convst_len", 32'(last_convst_len), 32'(CONV));
      checkOutput("ch6_busy_len", 32'(last_busy_len), 32'(2 * TRANS));

      // Register file read, rd_ack clear, and write-vs-ack collision
      $display("[TB] register file");
      override_en = 1'b1;
      override_code = 12'hABC;
      applyStimulus(8'h08, 1'b1, 1'b1);
      waitFrameEnd(3 * TRANS);
      tick();
      rd_addr = 3'd3;
      #1;
      checkOutput("rd_flag_set", 32'(rd_data), 32'h8ABC);
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      checkOutput("rd_flag_clear", 32'(rd_data), 32'h0ABC);
      override_code = 12'h5A5;
      applyStimulus(8'h08, 1'b1, 1'b1);
      n = 0;
      while (!result_valid && n < 3 * TRANS) begin
         tick();
         n++;
      end
      checkOutput("collide_seen", 32'(result_valid), 32'd1);
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      checkOutput("collide_set_wins", 32'(rd_data), 32'h85A5);
      waitFrameEnd(3 * TRANS);
      override_en = 1'b0;
      tick();

      // auto_run, then drop enable during the second frame's CONV
      $display("[TB] auto_run with enable drop");
      fc = frame_count;
      auto_run = 1'b1;
      applyStimulus(8'h01, 1'b0, 1'b1);
      n = 0;
      while (frame_count < fc + 2 && n < 3 * TRANS) begin
         tick();
         n++;
      end
      checkOutput("auto_restart", 32'(frame_count - fc), 32'd2);
      checkOutput("auto_busy_gap", 32'(last_low_len), 32'd1);
      checkOutput("auto_frame1_len", 32'(last_busy_len), 32'(2 * TRANS));
      repeat (10) tick();
      checkOutput("auto_in_conv", 32'(adc_convst), 32'd1);
      enable = 1'b0;
      waitFrameEnd(2 * TRANS);
      tick();
      checkOutput("auto_frame2_len", 32'(last_busy_len), 32'(TRANS));
      cr = convst_rises;
      auto_run = 1'b0;
      repeat (TRANS + 50) tick();
      checkOutput("stop_no_convst", 32'(convst_rises - cr), 32'd0);
      checkOutput("stop_busy", 32'(busy), 32'd0);
      enable = 1'b1;
      tick();

      // start with an empty mask, and start while busy
      $display("[TB] ignored starts");
      fc = frame_count;
      cr = convst_rises;
      ch_mask = 8'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (20) tick();
      checkOutput("mask0_busy", 32'(busy), 32'd0);
      checkOutput("mask0_frames", 32'(frame_count - fc), 32'd0);
      checkOutput("mask0_convst", 32'(convst_rises - cr), 32'd0);
      applyStimulus(8'h02, 1'b1, 1'b1);
      repeat (100) tick();
      fc = frame_count;
      ch_mask = 8'hFF;
      start = 1'b1;
      tick();
      start = 1'b0;
      waitFrameEnd(3 * TRANS);
      repeat (5) tick();
      checkOutput("busy_start_frames", 32'(frame_count - fc), 32'd0);
      checkOutput("busy_start_len", 32'(last_busy_len), 32'(2 * TRANS));
      checkOutput("busy_start_idle", 32'(busy), 32'd0);

      // Reset asserted at bit 5 of SHIFT
      $display("[TB] reset mid-shift");
      applyStimulus(8'h01, 1'b1, 1'b0);
      n = 0;
      while (!(busy && !adc_convst && sclk_bits == 5) && n < 2 * TRANS) begin
         tick();
         n++;
      end
      checkOutput("shift_bit5_reached", 32'(sclk_bits), 32'd5);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      checkOutput("mid_rst_convst", 32'(adc_convst), 32'd0);
      checkOutput("mid_rst_sclk", 32'(adc_sclk), 32'd0);
      checkOutput("mid_rst_din", 32'(adc_din), 32'd0);
      checkOutput("mid_rst_valid", 32'(result_valid), 32'd0);
      checkOutput("mid_rst_ch", 32'(result_ch), 32'd0);
      checkOutput("mid_rst_data", 32'(result_data), 32'd0);
      checkOutput("mid_rst_rd_data", 32'(rd_data), 32'd0);
      tick();
      reset_n = 1'b1;
      cr = convst_rises;
      repeat (50) tick();
      checkOutput("post_rst_busy", 32'(busy), 32'd0);
      checkOutput("post_rst_convst", 32'(convst_rises - cr), 32'd0);

      checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule

// File: doc/adc_ltc2308_sequencer.md
Name: adc_ltc2308_sequencer

Overview:
- Controller for the board's LTC2308 8-channel 12-bit SPI ADC (ADC_CONVST/ADC_SCLK/ADC_SDI/ADC_SDO pins).
- Scans a masked set of single-ended channels in ascending order, generates conversion and serial timing, and stores the latest result per channel.
- Results are readable by a bus-side register read port and also emitted as a one-cycle result stream.
- Runs in the system clock domain (100 MHz) beside the other memory-mapped peripherals.

Parameters:
- CONV_CYCLES, 170, clocks convst is held high per conversion (≥1.6 µs at 100 MHz).
- SCLK_HALF, 4, clocks per SCLK half-period (12.5 MHz at 100 MHz); must be ≥1.
- ACQ_CYCLES, 40, idle clocks after the shift phase before the next convst.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  level; 0 stops scanning at the next transaction boundary
- start  in  1  one-cycle pulse; begins one frame when idle
- auto_run  in  1  1 = start a new frame immediately after each frame ends
- ch_mask  in  8  bit n set = channel n is scanned
- busy  out  1  high from frame start to frame end
- adc_convst  out  1  to ADC_CONVST
- adc_sclk  out  1  to ADC_SCLK
- adc_din  out  1  to ADC_SDI (config word)
- adc_dout  in  1  from ADC_SDO
- result_valid  out  1  one-cycle pulse per stored result
- result_ch  out  3  channel of result_data
- result_data  out  12  conversion code
- rd_addr  in  3  register-file read channel
- rd_data  out  16  {update flag, 3'b0, code[11:0]} for rd_addr, combinational
- rd_ack  in  1  pulse; clears the update flag of channel rd_addr

Behaviour:
- Reset values: busy=0, adc_convst=0, adc_sclk=0, adc_din=0, result_valid=0, result_ch=0, result_data=0, all stored codes=0, all update flags=0; FSM=IDLE. Reset acts immediately, including mid-transaction.
- Frame start: in IDLE with enable=1 and (start=1 or auto_run=1) and ch_mask≠0.
  - Latch ch_mask into scan_mask.
  - busy=1 the next cycle.
  - ch_mask=0 never starts a frame and busy stays 0.
  - start while busy is ignored.
- Pipelining: each transaction sends the config for channel C(k+1) and returns the result configured by the previous transaction.
  - A frame with N enabled channels runs N+1 transactions.
  - Transaction 0's data is discarded; the last transaction sends channel C(N−1)'s config again.
- Config word, 6 bits, MSB first on adc_din: S/D=1, O/S=ch[0], S1=ch[2], S0=ch[1], UNI=1, SLP=0. Bits 7-12 of the shift phase drive adc_din=0.
- FSM states:
  - IDLE: all outputs quiescent.
  - CONV: adc_convst=1 for exactly CONV_CYCLES clocks.
  - SHIFT: adc_convst=0; 12 SCLK periods, each SCLK_HALF clocks low then SCLK_HALF clocks high.
    - adc_din changes only in the first clock of a low half.
    - adc_dout is sampled on the clock where adc_sclk goes 0→1, MSB first.
  - ACQ: adc_sclk=0 for ACQ_CYCLES clocks, then the next CONV or frame end.
- Transaction length: CONV_CYCLES + 24·SCLK_HALF + ACQ_CYCLES clocks (default 306).
- Result write: one clock after the 12th sample, for transactions 1..N:
  - result_valid=1 for 1 cycle with result_ch and result_data.
  - The code is written into channel result_ch and its update flag is set.
  - If rd_ack targets the same channel in the same cycle, the set wins.
- Frame end: after ACQ of transaction N.
  - busy falls to 0 for exactly one cycle, then the next frame starts if auto_run=1 and enable=1.
  - A ch_mask change takes effect only at a frame start.
- enable=0 mid-frame: the current transaction completes, including its result write; remaining transactions are skipped; FSM goes to IDLE and busy=0.
- Single channel (N=1): 2 transactions, both configuring that channel; 1 result.

Test Plan:
- Reset mid-SHIFT (assert reset_n=0 at bit 5) -> all outputs 0 in the same cycle; after release, FSM stays IDLE with busy=0 until start.
- ch_mask=8'b1010_0001, start pulse, ADC model returns 12'h100+ch -> 4 transactions. Configs sent: ch0, ch5, ch7, ch7. Results in order: ch0=0x100, ch5=0x105, ch7=0x107. busy high for 4×306 clocks.
- Config encoding: ch6 scanned -> SDI bits 1,0,1,1,1,0 on the first 6 rising SCLK edges. SCLK period is 8 clocks; convst high for 170 clocks.
- auto_run=1, ch_mask=8'h01, deassert enable during the 2nd frame's CONV -> that transaction completes; no further convst; busy=0 afterwards.
- Register file: after ch3 result 0xABC, rd_addr=3 -> rd_data=16'h8ABC. rd_ack gives 16'h0ABC the next cycle. rd_ack coinciding with a new ch3 write leaves the flag set.
- start with ch_mask=0, and start while busy -> no convst activity; frame count unchanged.
